// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access controller: request sizes and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/store_alignment.sv
// Store lane alignment: byte strobes, replicated write data and misalignment detection.
module store_alignment
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_aligned,
    output logic        misaligned
);

    logic [3:0] strb;

    always_comb begin
        strb          = 4'b1111;
        wdata_aligned = wdata;
        misaligned    = 1'b0;
        case (size)
            SIZE_B: begin
                strb          = 4'b0001 << offset;
                wdata_aligned = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                // upper lanes fall off the 4-bit strobe at offset 3
                strb          = 4'b0011 << offset;
                wdata_aligned = {2{wdata[15:0]}};
                misaligned    = offset[0];
            end
            default: begin
                strb       = 4'b1111;
                misaligned = (offset != 2'b00);
            end
        endcase
        wstrb = we ? strb : 4'b0000;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequential load/store controller driving a valid/ready data-memory bus.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | ready for a request, latch it on req_valid
// MEM   | bus request outstanding, wait for mem_ready
// RESP  | one-cycle response pulse
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_offset,
    output logic                  rsp_fault
);

    mem_state_t state, state_nxt;

    logic        r_we;
    logic [1:0]  r_offset;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        misaligned;
    logic        trap;

    store_alignment u_store_alignment (
        .size          (req_size),
        .offset        (req_addr[1:0]),
        .wdata         (req_wdata),
        .we            (req_we),
        .wstrb         (al_wstrb),
        .wdata_aligned (al_wdata),
        .misaligned    (misaligned)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = trap ? RESP : MEM;
            end
            MEM: begin
                mem_valid = 1'b1;
                if (mem_ready) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we       <= 1'b0;
            r_offset   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            rsp_rdata  <= '0;
            rsp_offset <= '0;
            rsp_fault  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                r_we     <= req_we;
                r_offset <= req_addr[1:0];
                if (trap) begin
                    // trapped requests answer straight away and leave the bus untouched
                    rsp_rdata  <= '0;
                    rsp_offset <= req_addr[1:0];
                    rsp_fault  <= 1'b1;
                end else begin
                    mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata <= al_wdata;
                    mem_wstrb <= al_wstrb;
                end
            end
            if (state == MEM && mem_ready) begin
                rsp_rdata  <= r_we ? 32'h0 : mem_rdata;
                rsp_offset <= r_offset;
                rsp_fault  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed requests against a byte-lane reference model.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, resetn;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_offset;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_offset(rsp_offset),
        .rsp_fault(rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int rsp_count = 0;
    int exp_rsp = 0;

    // model expectations for the request in flight, and for the last completed one
    logic        cur_we;
    logic [31:0] cur_addr, cur_wd, cur_rdata;
    logic [3:0]  cur_strb;
    logic [1:0]  cur_off;
    logic        cur_fault;
    logic [31:0] held_rdata = 32'h0;
    logic [1:0]  held_off = 2'b0;
    logic        held_fault = 1'b0;

    // observations of the DUT for literal pins
    logic [31:0] obs_addr, obs_wd, last_rdata;
    logic [3:0]  obs_strb;
    logic [1:0]  last_off;
    logic        last_fault;
    int          obs_lat;
    int          obs_mem_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        if (size == SIZE_B) return 1;
        if (size == SIZE_H) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_strb(input logic we, input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        s = 4'b0;
        for (int i = 0; i < 4; i++)
            if (we && i >= int'(off) && i < int'(off) + nbytes(size)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
        return r;
    endfunction

    function automatic bit m_mis(input logic [1:0] size, input logic [1:0] off);
        return (int'(off) % nbytes(size)) != 0;
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (mem_valid) begin
                check("bus_addr", mem_addr, cur_addr);
                check("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, cur_strb});
                if (cur_we) check("bus_wdata", mem_wdata, cur_wd);
            end
            if (rsp_valid) begin
                rsp_count++;
                check("rsp_rdata", rsp_rdata, cur_rdata);
                check("rsp_offset", {30'b0, rsp_offset}, {30'b0, cur_off});
                check("rsp_fault", {31'b0, rsp_fault}, {31'b0, cur_fault});
                held_rdata = cur_rdata;
                held_off   = cur_off;
                held_fault = cur_fault;
            end else begin
                check("hold_rdata", rsp_rdata, held_rdata);
                check("hold_offset", {30'b0, rsp_offset}, {30'b0, held_off});
                check("hold_fault", {31'b0, rsp_fault}, {31'b0, held_fault});
            end
        end
    end

    task automatic set_model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd);
        cur_we    = we;
        cur_fault = TRAP && m_mis(size, addr[1:0]);
        cur_addr  = {addr[31:2], 2'b00};
        cur_strb  = m_strb(we, size, addr[1:0]);
        cur_wd    = m_wdata(size, wd);
        cur_off   = addr[1:0];
        cur_rdata = (we || cur_fault) ? 32'h0 : rd;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd);
        bit got;
        @(negedge clk);
        set_model(we, size, addr, wd, rd);
        exp_rsp++;
        obs_addr = 'x; obs_wd = 'x; obs_strb = 'x; obs_lat = -1; obs_mem_cycles = 0;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= waits + 4 && !got; k++) begin
            @(negedge clk);
            check("mem_valid_phase", {31'b0, mem_valid},
                  {31'b0, (!cur_fault && k <= waits + 1)});
            if (mem_valid) obs_mem_cycles++;
            if (mem_valid && k == 1) begin
                obs_addr = mem_addr; obs_wd = mem_wdata; obs_strb = mem_wstrb;
            end
            if (rsp_valid) begin
                got = 1'b1; obs_lat = k;
                last_rdata = rsp_rdata; last_off = rsp_offset; last_fault = rsp_fault;
            end
            if (!cur_fault && k == waits + 1) begin
                mem_ready = 1'b1; mem_rdata = rd;
            end
            @(posedge clk);
            #1 mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        end
        check("rsp_latency", obs_lat, cur_fault ? 32'd1 : waits + 2);
    endtask

    initial begin
        int acc;
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        set_model(1'b0, SIZE_W, 32'h0, 32'h0, 32'h0);
        #23;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_offset", {30'b0, rsp_offset}, 32'h0);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 32'h0);
        @(negedge clk) resetn = 1'b1;

        do_req(1'b1, SIZE_B, 32'h1003, 32'h0000_00A5, 0, 32'h0);
        check("sb_addr", obs_addr, 32'h1000);
        check("sb_strb", {28'b0, obs_strb}, 32'h8);
        check("sb_wdata", obs_wd, 32'hA5A5_A5A5);
        check("sb_lat", obs_lat, 32'd2);

        do_req(1'b0, SIZE_H, 32'h2002, 32'h0, 3, 32'h8001_7F00);
        check("lh_strb", {28'b0, obs_strb}, 32'h0);
        check("lh_rdata", last_rdata, 32'h8001_7F00);
        check("lh_off", {30'b0, last_off}, 32'd2);
        check("lh_lat", obs_lat, 32'd5);

        do_req(1'b0, SIZE_W, 32'h3001, 32'h0, 1, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_mis_lat", obs_lat, 32'd1);
        check("lw_mis_fault", {31'b0, last_fault}, 32'd1);
        check("lw_mis_rdata", last_rdata, 32'h0);
        check("lw_mis_nobus", obs_mem_cycles, 32'd0);
`else
        check("lw_mis_addr", obs_addr, 32'h3000);
        check("lw_mis_fault", {31'b0, last_fault}, 32'd0);
        check("lw_mis_rdata", last_rdata, 32'hCAFE_F00D);
`endif

        do_req(1'b1, SIZE_H, 32'h4003, 32'h0000_1234, 0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("sh_mis_fault", {31'b0, last_fault}, 32'd1);
        check("sh_mis_nobus", obs_mem_cycles, 32'd0);
`else
        check("sh_mis_strb", {28'b0, obs_strb}, 32'h8);
        check("sh_mis_wdata", obs_wd, 32'h1234_1234);
`endif

        do_req(1'b1, SIZE_H, 32'h6002, 32'h0000_BEEF, 2, 32'h0);
        check("sh_strb", {28'b0, obs_strb}, 32'hC);
        check("sh_wdata", obs_wd, 32'hBEEF_BEEF);

        do_req(1'b1, 2'd3, 32'h5000, 32'h0102_0304, 0, 32'h0);
        check("s3_strb", {28'b0, obs_strb}, 32'hF);
        check("s3_wdata", obs_wd, 32'h0102_0304);

        do_req(1'b1, SIZE_B, 32'h7001, 32'h0000_003C, 1, 32'h0);
        check("sb1_strb", {28'b0, obs_strb}, 32'h2);
        check("sb1_wdata", obs_wd, 32'h3C3C_3C3C);

        do_req(1'b0, SIZE_B, 32'h9003, 32'h0, 0, 32'h55AA_1234);
        check("lb_off", {30'b0, last_off}, 32'd3);
        check("lb_rdata", last_rdata, 32'h55AA_1234);

        // reset while the bus request is outstanding
        @(negedge clk);
        set_model(1'b0, SIZE_W, 32'hA000, 32'h0, 32'h1111_2222);
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_addr = 32'hA000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_valid_before", {31'b0, mem_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'h0);
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        held_rdata = 32'h0; held_off = 2'b0; held_fault = 1'b0;
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
            check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        end

        // request held continuously with a zero-wait bus
        set_model(1'b0, SIZE_B, 32'h8001, 32'h0, 32'h1122_3344);
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_B; req_addr = 32'h8001;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        req_valid = 1'b0;
        exp_rsp += 4;
        @(posedge clk);
        #1 mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("hold_accepts", acc, 32'd4);
        check("rsp_pulse_count", rsp_count, exp_rsp);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
